// File: rtl/enum_type.sv
// Shared game-state encoding for the Tetris engine and its command path.
package enum_type;

    typedef enum logic [3:0] {
        NONE   = 4'd0,
        WAIT   = 4'd1,
        LEFT   = 4'd2,
        RIGHT  = 4'd3,
        DOWN   = 4'd4,
        DROP   = 4'd5,
        ROTATE = 4'd6,
        BAR    = 4'd7
    } state_type;

    localparam int CMD_W = $bits(state_type);

endpackage

// File: rtl/cmd_arbiter_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last_q;
    logic [IW-1:0] last_d;
    logic [IW-1:0] grant_idx;
    logic          found;

    // Pick the first requester after the last grant, wrapping modulo N.
    always_comb begin
        grant     = '0;
        grant_idx = last_q;
        found     = 1'b0;
        for (int off = 1; off <= N; off++) begin
            if (!found && req[(int'(last_q) + off) % N]) begin
                found = 1'b1;
                grant[(int'(last_q) + off) % N] = 1'b1;
                grant_idx = IW'((int'(last_q) + off) % N);
            end
        end
        last_d = advance ? grant_idx : last_q;
    end

    // Pointer moves only when the grant actually turned into a transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/cmd_arbiter.sv
// Two-class round-robin merge of game commands into a FIFO; one command is
// issued per engine WAIT window as a single-cycle pulse on control.
// Optional macro CMD_COALESCE_EN: drop repeated low-class DOWN/BAR commands
// that match the most recently queued entry and count them.
module cmd_arbiter
    import enum_type::*;
#(
    parameter int               NREQ      = 4,
    parameter int               QSIZE     = 16,
    parameter logic [NREQ-1:0]  PRIO_MASK = 4'b0011
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*CMD_W-1:0]     req_cmd,
    output logic [NREQ-1:0]           req_ready,
    input  state_type                 state,
    input  logic                      flush,
    output state_type                 control,
    output logic [$clog2(QSIZE):0]    q_count,
    output logic [15:0]               coalesce_cnt
);

    localparam int AW = $clog2(QSIZE);
    localparam int CW = AW + 1;

    state_type       mem [QSIZE];
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    state_type       control_q, control_d;

    state_type       cmd_a [NREQ];
    logic [NREQ-1:0] elig, hi_grant, lo_grant, grant;
    logic            any_hi, any_elig, pop, full, blocked, transfer, push, coal;
    logic            hi_adv, lo_adv;
    state_type       grant_cmd;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign cmd_a[gi] = state_type'(req_cmd[gi*CMD_W +: CMD_W]);
            assign elig[gi]  = req_valid[gi] && (cmd_a[gi] != NONE);
        end
    endgenerate

    rr_arbiter #(.N(NREQ)) u_hi (
        .clk(clk), .reset_n(reset_n), .req(elig & PRIO_MASK),
        .advance(hi_adv), .grant(hi_grant)
    );

    rr_arbiter #(.N(NREQ)) u_lo (
        .clk(clk), .reset_n(reset_n), .req(elig & ~PRIO_MASK),
        .advance(lo_adv), .grant(lo_grant)
    );

    // Grant selection, handshake and FIFO next-state.
    always_comb begin
        any_hi    = |(elig & PRIO_MASK);
        any_elig  = |elig;
        grant     = any_hi ? hi_grant : lo_grant;
        grant_cmd = NONE;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_cmd = cmd_a[i];
        end
        pop     = (state == WAIT) && (count_q != '0) && (control_q == NONE) && !flush;
        full    = (count_q == CW'(QSIZE));
        blocked = flush || (full && !pop) || !reset_n;
        if (blocked)       req_ready = '0;
        else if (any_elig) req_ready = grant;
        else               req_ready = req_valid;   // NONE commands are simply discarded
        transfer = !blocked && any_elig;
        hi_adv   = transfer && any_hi;
        lo_adv   = transfer && !any_hi;
        push     = transfer && !coal;

        wptr_d    = wptr_q + AW'(push);
        rptr_d    = rptr_q + AW'(pop);
        count_d   = count_q + CW'(push) - CW'(pop);
        control_d = pop ? mem[rptr_q] : NONE;
        if (flush) begin
            wptr_d    = '0;
            rptr_d    = '0;
            count_d   = '0;
            control_d = NONE;
        end
    end

`ifdef CMD_COALESCE_EN
    state_type tail_q, tail_d;
    logic [15:0] coal_cnt_q, coal_cnt_d;
    logic        tail_live;

    // A tail entry being popped right now is no longer a coalescing target.
    always_comb begin
        tail_live  = (count_q != '0) && !((count_q == CW'(1)) && pop);
        coal       = !any_hi && ((grant_cmd == DOWN) || (grant_cmd == BAR))
                     && tail_live && (tail_q == grant_cmd);
        tail_d     = push ? grant_cmd : tail_q;
        coal_cnt_d = coal_cnt_q;
        if (transfer && coal && (coal_cnt_q != 16'hFFFF)) coal_cnt_d = coal_cnt_q + 16'd1;
    end

    // Remember the last pushed command and the saturating coalesce count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tail_q     <= NONE;
            coal_cnt_q <= '0;
        end else begin
            tail_q     <= tail_d;
            coal_cnt_q <= coal_cnt_d;
        end
    end

    assign coalesce_cnt = coal_cnt_q;
`else
    assign coal         = 1'b0;
    assign coalesce_cnt = '0;
`endif

    // Queue storage: write at the tail, read only through the control register.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr_q] <= grant_cmd;
    end

    // Pointers, occupancy and the issued-command register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            control_q <= NONE;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            control_q <= control_d;
        end
    end

    assign control = control_q;
    assign q_count = count_q;

endmodule
